mips_processor_top: RTL and testbench

//  Single-cycle 32-bit MIPS-subset processor with on-chip instruction and data memories.

---
 rtl/mips_processor_top.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_processor_top.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_processor_top.sv
//------------------------------------------------------------------------------
// Module      : mips_processor_top
// Description : Single-cycle 32-bit MIPS-subset processor with on-chip word-
//               addressed instruction and data memories. Both memories are
//               loaded through dedicated external write ports. After reset
//               release the core executes from word 0 until HALT, then raises
//               a sticky done flag. processor_out holds the most recent SW value.
// Config      : HALT_ON_INVALID_EN - when defined, an undefined opcode behaves
//               like HALT. When undefined, it is treated as a NOP.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_processor_top #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int MEM_DEPTH = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instr,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic              ins_we,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              data_we,
   output logic [DATA_W-1:0] processor_out,
   output logic              done
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // R-type function codes
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [ADDR_W-1:0] PC_ONE   = 1;
   localparam logic [DATA_W-1:0] DATA_ONE = 1;

   // Architectural state
   logic [DATA_W-1:0] imem [0:MEM_DEPTH-1];
   logic [DATA_W-1:0] dmem [0:MEM_DEPTH-1];
   logic [DATA_W-1:0] regs [0:31];
   logic [ADDR_W-1:0] pc;

   // Fetch / decode fields
   logic [DATA_W-1:0] cur;
   logic [5:0]        opcode;
   logic [4:0]        rs_idx;
   logic [4:0]        rt_idx;
   logic [4:0]        rd_idx;
   logic [5:0]        funct;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] addr_sum;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] pc_plus1;

   // Per-instruction control results
   logic [ADDR_W-1:0] next_pc;
   logic              reg_we;
   logic [4:0]        wr_idx;
   logic [DATA_W-1:0] wr_val;
   logic              store;
   logic              halt_now;

   // The core advances only when no external load is in progress and it has
   // not halted; external loads always take priority over execution.
   logic stall;
   logic run;

   assign stall = ins_we | data_we;
   assign run   = ~stall & ~done;

   assign cur      = imem[pc];
   assign opcode   = cur[31:26];
   assign rs_idx   = cur[25:21];
   assign rt_idx   = cur[20:16];
   assign rd_idx   = cur[15:11];
   assign funct    = cur[5:0];
   assign imm_sext = {{(DATA_W-16){cur[15]}}, cur[15:0]};

   // $0 is hard-wired to zero regardless of what the array holds
   assign rs_val   = (rs_idx == 5'd0) ? '0 : regs[rs_idx];
   assign rt_val   = (rt_idx == 5'd0) ? '0 : regs[rt_idx];

   // Shared adder for LW/SW address and ADDI; memory address wraps to ADDR_W bits
   assign addr_sum = rs_val + imm_sext;
   assign mem_addr = addr_sum[ADDR_W-1:0];
   assign pc_plus1 = pc + PC_ONE;

   // Decode and execute: next PC, register write-back, store and halt requests
   always_comb begin
      next_pc  = pc_plus1;
      reg_we   = 1'b0;
      wr_idx   = rd_idx;
      wr_val   = '0;
      store    = 1'b0;
      halt_now = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin
                  reg_we = 1'b1;
                  wr_val = rs_val + rt_val;
               end
               FN_SUB: begin
                  reg_we = 1'b1;
                  wr_val = rs_val - rt_val;
               end
               FN_AND: begin
                  reg_we = 1'b1;
                  wr_val = rs_val & rt_val;
               end
               FN_OR: begin
                  reg_we = 1'b1;
                  wr_val = rs_val | rt_val;
               end
               FN_SLT: begin
                  reg_we = 1'b1;
                  wr_val = ($signed(rs_val) < $signed(rt_val)) ? DATA_ONE : '0;
               end
               default: begin
                  // Unlisted function codes (including 0x00) retire as NOP
                  reg_we = 1'b0;
               end
            endcase
         end
         OP_LW: begin
            reg_we = 1'b1;
            wr_idx = rt_idx;
            wr_val = dmem[mem_addr];
         end
         OP_SW: begin
            store = 1'b1;
         end
         OP_ADDI: begin
            reg_we = 1'b1;
            wr_idx = rt_idx;
            wr_val = addr_sum;
         end
         OP_BEQ: begin
            if (rs_val == rt_val) begin
               next_pc = pc_plus1 + cur[ADDR_W-1:0];
            end
         end
         OP_J: begin
            next_pc = cur[ADDR_W-1:0];
         end
         OP_HALT: begin
            halt_now = 1'b1;
            next_pc  = pc;
         end
         default: begin
`ifdef HALT_ON_INVALID_EN
            halt_now = 1'b1;
            next_pc  = pc;
`else
            halt_now = 1'b0;
`endif
         end
      endcase
   end

   // Program counter, sticky done flag and last-stored-word output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc            <= '0;
         done          <= 1'b0;
         processor_out <= '0;
      end else if (run) begin
         pc <= next_pc;
         if (halt_now) begin
            done <= 1'b1;
         end
         if (store) begin
            processor_out <= rt_val;
         end
      end
   end

   // Register file write-back; writes targeting $0 are discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (run && reg_we && (wr_idx != 5'd0)) begin
         regs[wr_idx] <= wr_val;
      end
   end

   // Instruction memory: external load port only, contents survive reset
   always_ff @(posedge clk) begin
      if (ins_we) begin
         imem[instr_addr] <= instr;
      end
   end

   // Data memory: external load wins; core stores only happen while running
   always_ff @(posedge clk) begin
      if (data_we) begin
         dmem[data_addr] <= data;
      end else if (run && store) begin
         dmem[mem_addr] <= rt_val;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mips_processor_top.sv
`default_nettype none

module tb_mips_processor_top;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [9:0]  instr_addr;
   logic        ins_we;
   logic [31:0] data;
   logic [9:0]  data_addr;
   logic        data_we;
   logic [31:0] processor_out;
   logic        done;

   int n_checks;
   int n_fail;

   localparam logic [31:0] HALT_W = 32'hFC00_0000;

   mips_processor_top dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .instr_addr    (instr_addr),
      .ins_we        (ins_we),
      .data          (data),
      .data_addr     (data_addr),
      .data_we       (data_we),
      .processor_out (processor_out),
      .done          (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   task automatic wr_imem(input int a, input logic [31:0] w);
      @(negedge clk);
      instr_addr = a[9:0];
      instr      = w;
      ins_we     = 1'b1;
      @(negedge clk);
      ins_we     = 1'b0;
   endtask

   task automatic wr_dmem(input int a, input logic [31:0] w);
      @(negedge clk);
      data_addr = a[9:0];
      data      = w;
      data_we   = 1'b1;
      @(negedge clk);
      data_we   = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold_reset;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic release_reset;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // LW $8,0; LW $9,1; ADD $10,$8,$9; SW $10,2; HALT with dmem[0]=5, dmem[1]=10
   task automatic load_add_prog;
      wr_dmem(0, 32'd5);
      wr_dmem(1, 32'd10);
      wr_imem(0, enc_i(6'h23, 5'd0, 5'd8, 16'd0));
      wr_imem(1, enc_i(6'h23, 5'd0, 5'd9, 16'd1));
      wr_imem(2, enc_r(5'd8, 5'd9, 5'd10, 6'h20));
      wr_imem(3, enc_i(6'h2B, 5'd0, 5'd10, 16'd2));
      wr_imem(4, HALT_W);
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if (processor_out !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_out actual=%0h expected=0", processor_out);
      end
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done actual=%0b expected=0", done);
      end
   endtask

   task automatic test_load_add;
      load_add_prog();
      release_reset();
      step(4);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL add_done_early actual=%0b expected=0", done);
      end
      step(1);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL add_done actual=%0b expected=1", done);
      end
      n_checks++;
      if (processor_out !== 32'd15) begin
         n_fail++;
         $display("FAIL add_out actual=%0h expected=f", processor_out);
      end
      n_checks++;
      if (dut.dmem[2] !== 32'd15) begin
         n_fail++;
         $display("FAIL add_dmem2 actual=%0h expected=f", dut.dmem[2]);
      end
      // done is sticky after further clocks
      step(3);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL add_done_sticky actual=%0b expected=1", done);
      end
   endtask

   task automatic test_reset_midrun;
      hold_reset();
      #1;
      n_checks++;
      if (done !== 1'b0 || processor_out !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_after_halt actual done=%0b out=%0h expected done=0 out=0", done, processor_out);
      end
      release_reset();
      step(4);
      n_checks++;
      if (processor_out !== 32'd15 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_pre actual done=%0b out=%0h expected done=0 out=f", done, processor_out);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (processor_out !== 32'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_async actual done=%0b out=%0h expected done=0 out=0", done, processor_out);
      end
      release_reset();
      step(5);
      n_checks++;
      if (processor_out !== 32'd15 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_rerun actual done=%0b out=%0h expected done=1 out=f", done, processor_out);
      end
   endtask

   task automatic test_slt;
      hold_reset();
      wr_imem(0, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));   // ADDI $1,$0,-1
      wr_imem(1, enc_r(5'd1, 5'd0, 5'd2, 6'h2A));       // SLT $2,$1,$0
      wr_imem(2, enc_i(6'h04, 5'd2, 5'd0, 16'd1));      // BEQ $2,$0,+1 (not taken)
      wr_imem(3, enc_i(6'h2B, 5'd0, 5'd2, 16'd0));      // SW $2,0
      wr_imem(4, HALT_W);
      release_reset();
      step(4);
      n_checks++;
      if (processor_out !== 32'd1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL slt_out actual done=%0b out=%0h expected done=0 out=1", done, processor_out);
      end
      step(1);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL slt_done actual=%0b expected=1", done);
      end
   endtask

   task automatic test_alu;
      hold_reset();
      wr_dmem(1023, 32'h1234_5678);
      wr_imem(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd12));    // $1 = 12
      wr_imem(1,  enc_i(6'h08, 5'd0, 5'd2, 16'd10));    // $2 = 10
      wr_imem(2,  enc_r(5'd1, 5'd2, 5'd3, 6'h22));      // $3 = 2
      wr_imem(3,  enc_r(5'd1, 5'd2, 5'd4, 6'h24));      // $4 = 8
      wr_imem(4,  enc_r(5'd1, 5'd2, 5'd5, 6'h25));      // $5 = 14
      wr_imem(5,  enc_r(5'd3, 5'd4, 5'd6, 6'h20));      // $6 = 10
      wr_imem(6,  enc_r(5'd6, 5'd5, 5'd6, 6'h20));      // $6 = 24
      wr_imem(7,  enc_r(5'd1, 5'd2, 5'd6, 6'h00));      // funct 0 -> NOP
      wr_imem(8,  enc_i(6'h2B, 5'd0, 5'd6, 16'd5));     // SW $6,5
      wr_imem(9,  enc_i(6'h23, 5'd8, 5'd7, 16'hFFFF));  // LW $7,-1($8) -> dmem[1023]
      wr_imem(10, enc_i(6'h2B, 5'd0, 5'd7, 16'd4));     // SW $7,4
      wr_imem(11, HALT_W);
      release_reset();
      step(9);
      n_checks++;
      if (processor_out !== 32'd24) begin
         n_fail++;
         $display("FAIL alu_out actual=%0h expected=18", processor_out);
      end
      step(2);
      n_checks++;
      if (processor_out !== 32'h1234_5678 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_wrap actual done=%0b out=%0h expected done=0 out=12345678", done, processor_out);
      end
      step(1);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL alu_done actual=%0b expected=1", done);
      end
   endtask

   task automatic test_branch_jump;
      hold_reset();
      wr_imem(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd3));     // $1 = 3
      wr_imem(1,  enc_i(6'h08, 5'd0, 5'd2, 16'd7));     // $2 = 7
      wr_imem(2,  enc_i(6'h2B, 5'd0, 5'd1, 16'd0));     // SW 3
      wr_imem(3,  enc_i(6'h04, 5'd0, 5'd0, 16'd1));     // BEQ taken -> 5
      wr_imem(4,  enc_i(6'h2B, 5'd0, 5'd2, 16'd1));     // SW 7 (skipped)
      wr_imem(5,  enc_r(5'd1, 5'd2, 5'd0, 6'h20));      // ADD $0,$1,$2
      wr_imem(6,  enc_j(26'd9));                        // J 9
      wr_imem(7,  enc_i(6'h2B, 5'd0, 5'd2, 16'd2));     // SW 7 (skipped)
      wr_imem(8,  HALT_W);
      wr_imem(9,  enc_i(6'h2B, 5'd0, 5'd0, 16'd3));     // SW $0
      wr_imem(10, HALT_W);
      release_reset();
      step(5);
      n_checks++;
      if (processor_out !== 32'd3) begin
         n_fail++;
         $display("FAIL beq_skip actual=%0h expected=3", processor_out);
      end
      step(2);
      n_checks++;
      if (processor_out !== 32'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_zero_reg actual done=%0b out=%0h expected done=0 out=0", done, processor_out);
      end
      step(1);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_done actual=%0b expected=1", done);
      end
   endtask

   task automatic test_stall;
      hold_reset();
      load_add_prog();
      release_reset();
      step(2);
      @(negedge clk);
      instr_addr = 10'd100;
      instr      = 32'd0;
      ins_we     = 1'b1;
      @(negedge clk);
      ins_we     = 1'b0;
      step(1);
      @(negedge clk);
      data_addr  = 10'd50;
      data       = 32'hDEAD_BEEF;
      data_we    = 1'b1;
      @(negedge clk);
      data_we    = 1'b0;
      step(1);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_done_early actual=%0b expected=0", done);
      end
      step(1);
      n_checks++;
      if (done !== 1'b1 || processor_out !== 32'd15) begin
         n_fail++;
         $display("FAIL stall_result actual done=%0b out=%0h expected done=1 out=f", done, processor_out);
      end
   endtask

   task automatic test_invalid;
      hold_reset();
      wr_imem(0, enc_i(6'h08, 5'd0, 5'd1, 16'd9));      // $1 = 9
      wr_imem(1, {6'h3E, 26'd0});                       // undefined opcode
      wr_imem(2, enc_i(6'h2B, 5'd0, 5'd1, 16'd0));      // SW $1,0
      wr_imem(3, HALT_W);
      release_reset();
      step(2);
`ifdef HALT_ON_INVALID_EN
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_halt actual=%0b expected=1", done);
      end
      step(2);
      n_checks++;
      if (processor_out !== 32'd0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_frozen actual done=%0b out=%0h expected done=1 out=0", done, processor_out);
      end
`else
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL invalid_nop actual=%0b expected=0", done);
      end
      step(2);
      n_checks++;
      if (processor_out !== 32'd9 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_continue actual done=%0b out=%0h expected done=1 out=9", done, processor_out);
      end
`endif
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      instr      = '0;
      instr_addr = '0;
      ins_we     = 1'b0;
      data       = '0;
      data_addr  = '0;
      data_we    = 1'b0;
      #2 rst     = 1'b0;
      test_reset();
      test_load_add();
      test_reset_midrun();
      test_slt();
      test_alu();
      test_branch_jump();
      test_stall();
      test_invalid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
